wt_dcache_tree_plru: RTL and testbench

- Parametrised tree-pseudo-LRU replacement unit for the write-through L1 dcache.
- Handles any power-of-two associativity.
- Supports predictor-driven insertion: a fill is inserted either at MRU or at LRU.
- Invalid ways are chosen as victims before any tree lookup.
- Flush is a sequenced sweep, one set per cycle.
- Sits beside the dcache memory array. It receives hit updates from the read ports and fill commits from the miss unit, and provides the victim way to the miss unit.

---
 rtl/wt_cache_pkg.sv | 31 +++
 rtl/wt_plru_tree_update.sv | 28 ++
 rtl/wt_dcache_tree_plru.sv | 146 ++++++++++++++
 tb/tb_wt_dcache_tree_plru.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through dcache tree-PLRU replacement logic.
// Tree storage is sized for the widest supported associativity; users slice or extend.
package wt_cache_pkg;

  localparam int PLRU_MAX_WAYS  = 64;
  localparam int PLRU_MAX_WAY_W = 6;

  typedef logic [PLRU_MAX_WAYS-2:0] plru_tree_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

  // Walk from the root following each node bit; the taken branches spell the way index MSB first.
  function automatic logic [PLRU_MAX_WAY_W-1:0] plru_victim(input plru_tree_t tree, input int way_w);
    logic [PLRU_MAX_WAY_W-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < PLRU_MAX_WAY_W; l++) begin
      if (l < way_w) begin
        way  = {way[PLRU_MAX_WAY_W-2:0], tree[node[PLRU_MAX_WAY_W-1:0]]};
        node = 2 * node + 1 + int'(tree[node[PLRU_MAX_WAY_W-1:0]]);
      end
    end
    return way;
  endfunction

endpackage

// File: rtl/wt_plru_tree_update.sv
// Next-state of one PLRU tree after a touch (mru = 1) or an LRU insertion (mru = 0) of one way.
// Only the nodes on the way's root-to-leaf path are rewritten.
module wt_plru_tree_update #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree,
  input  logic [WAY_W-1:0]    way,
  input  logic                mru,
  output logic [NUM_WAYS-2:0] tree_next
);

  always_comb begin
    int   node;
    logic dir;
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    tree_next = tree;
    node      = 0;
    dir       = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = way[WAY_W-1-l];
      // A touch points the node away from the way; an LRU insertion points it toward the way.
      tree_next[node[WAY_W-1:0]] = mru ? ~dir : dir;
      node = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/wt_dcache_tree_plru.sv
// Tree-PLRU replacement state for the write-through L1 dcache: hit/fill updates,
// invalid-first victim selection and a one-set-per-cycle flush sweep.
module wt_dcache_tree_plru
  import wt_cache_pkg::*;
#(
  parameter int NUM_SETS = 256,
  parameter int NUM_WAYS = 4,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                flush_done_o,
  input  logic                hit_valid_i,
  input  logic [IDX_W-1:0]    hit_idx_i,
  input  logic [WAY_W-1:0]    hit_way_i,
  input  logic [IDX_W-1:0]    lookup_idx_i,
  input  logic [NUM_WAYS-1:0] valid_ways_i,
  output logic [WAY_W-1:0]    victim_way_o,
  input  logic                fill_valid_i,
  input  logic [IDX_W-1:0]    fill_idx_i,
  input  logic [WAY_W-1:0]    fill_way_i,
  input  logic                fill_mru_i
);

  if (NUM_WAYS < 2 || NUM_WAYS > PLRU_MAX_WAYS || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
    $error("wt_dcache_tree_plru: NUM_WAYS must be a power of two between 2 and 64");
  end

  logic [NUM_WAYS-2:0] state_q [NUM_SETS];

  flush_state_e     fsm_q, fsm_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             clear_en;
  logic             upd_ok;

  // ---------------- flush sequencer ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    busy_o       = 1'b0;
    flush_done_o = 1'b0;
    clear_en     = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (flush_i) begin
          fsm_d = FLUSH;
          cnt_d = '0;
        end
      end
      FLUSH: begin
        busy_o   = 1'b1;
        clear_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        // Stop on the last index rather than relying on the counter wrapping.
        if (cnt_q == IDX_W'(NUM_SETS - 1)) fsm_d = DONE;
      end
      DONE: begin
        flush_done_o = 1'b1;
        fsm_d        = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // A flush request wins over updates arriving in the same idle cycle.
  assign upd_ok = (fsm_q != FLUSH) && !((fsm_q == IDLE) && flush_i);

  // ---------------- update datapath ----------------
  logic                fill_en, hit_en, same_set;
  logic [NUM_WAYS-2:0] fill_tree, hit_base, hit_tree;

  assign fill_en  = fill_valid_i && upd_ok;
  assign hit_en   = hit_valid_i && upd_ok;
  assign same_set = fill_en && (fill_idx_i == hit_idx_i);
  // A same-set hit is layered on top of the fill so the hit way ends as MRU.
  assign hit_base = same_set ? fill_tree : state_q[hit_idx_i];

  wt_plru_tree_update #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_fill_update (
    .tree      (state_q[fill_idx_i]),
    .way       (fill_way_i),
    .mru       (fill_mru_i),
    .tree_next (fill_tree)
  );

  wt_plru_tree_update #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_hit_update (
    .tree      (hit_base),
    .way       (hit_way_i),
    .mru       (1'b1),
    .tree_next (hit_tree)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: this array is built from resettable flops because an async reset must clear every tree at once.
    if (!rst_ni) begin
      for (int s = 0; s < NUM_SETS; s++) state_q[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        if (clear_en && cnt_q == IDX_W'(s)) begin
          state_q[s] <= '0;
        end else if (hit_en && hit_idx_i == IDX_W'(s)) begin
          state_q[s] <= hit_tree;
        end else if (fill_en && fill_idx_i == IDX_W'(s)) begin
          state_q[s] <= fill_tree;
        end
      end
    end
  end

  // ---------------- victim selection ----------------
  logic [WAY_W-1:0] invalid_way, tree_way;
  logic             any_invalid;

  always_comb begin
    invalid_way = '0;
    any_invalid = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!valid_ways_i[i] && !any_invalid) begin
        invalid_way = WAY_W'(i);
        any_invalid = 1'b1;
      end
    end
  end

  assign tree_way = WAY_W'(plru_victim(plru_tree_t'(state_q[lookup_idx_i]), WAY_W));

  always_comb begin
    if (busy_o)           victim_way_o = '0;
    else if (any_invalid) victim_way_o = invalid_way;
    else                  victim_way_o = tree_way;
  end

endmodule

// File: tb/tb_wt_dcache_tree_plru.sv
// Self-checking bench for wt_dcache_tree_plru: directed cases, random traffic against an
// interval-halving PLRU model, and flush sweep / reset-during-sweep scenarios.
module tb_wt_dcache_tree_plru;

  localparam int NUM_SETS = 256;
  localparam int NUM_WAYS = 4;
  localparam int IDX_W    = 8;
  localparam int WAY_W    = 2;
  localparam int ALL_V    = (1 << NUM_WAYS) - 1;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic                busy;
  logic                flush_done;
  logic                hit_valid;
  logic [IDX_W-1:0]    hit_idx;
  logic [WAY_W-1:0]    hit_way;
  logic [IDX_W-1:0]    lookup_idx;
  logic [NUM_WAYS-1:0] valid_ways;
  logic [WAY_W-1:0]    victim_way;
  logic                fill_valid;
  logic [IDX_W-1:0]    fill_idx;
  logic [WAY_W-1:0]    fill_way;
  logic                fill_mru;

  int n_checks = 0;
  int n_errors = 0;

  // Model: one direction flag per tree node, navigated by halving the way interval.
  bit mtree [NUM_SETS][NUM_WAYS-1];

  wt_dcache_tree_plru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .busy_o       (busy),
    .flush_done_o (flush_done),
    .hit_valid_i  (hit_valid),
    .hit_idx_i    (hit_idx),
    .hit_way_i    (hit_way),
    .lookup_idx_i (lookup_idx),
    .valid_ways_i (valid_ways),
    .victim_way_o (victim_way),
    .fill_valid_i (fill_valid),
    .fill_idx_i   (fill_idx),
    .fill_way_i   (fill_way),
    .fill_mru_i   (fill_mru)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_victim(input int set, input int mask);
    int lo, size, node;
    if (mask != ALL_V) begin
      for (int i = 0; i < NUM_WAYS; i++)
        if (((mask >> i) & 1) == 0) return i;
    end
    lo = 0; size = NUM_WAYS; node = 0;
    while (size > 1) begin
      size = size / 2;
      if (mtree[set][node]) begin
        lo   = lo + size;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
    end
    return lo;
  endfunction

  // toward = 1: the path leads to the way (next victim); toward = 0: path leads away (MRU).
  task automatic m_apply(input int set, input int way, input bit toward);
    int lo, size, node;
    bit right;
    lo = 0; size = NUM_WAYS; node = 0;
    while (size > 1) begin
      size  = size / 2;
      right = (way >= lo + size);
      mtree[set][node] = toward ? right : !right;
      if (right) begin
        lo   = lo + size;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < NUM_SETS; s++)
      for (int n = 0; n < NUM_WAYS - 1; n++) mtree[s][n] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle carrying optional fill and hit; the model applies fill first, then hit.
  task automatic update(input bit hv, input int hi, input int hw,
                        input bit fv, input int fi, input int fw, input bit fm);
    hit_valid  = hv;
    hit_idx    = IDX_W'(hi);
    hit_way    = WAY_W'(hw);
    fill_valid = fv;
    fill_idx   = IDX_W'(fi);
    fill_way   = WAY_W'(fw);
    fill_mru   = fm;
    tick();
    hit_valid  = 1'b0;
    fill_valid = 1'b0;
    if (fv) m_apply(fi, fw, !fm);
    if (hv) m_apply(hi, hw, 1'b0);
  endtask

  task automatic probe(input string tag, input int set, input int mask);
    lookup_idx = IDX_W'(set);
    valid_ways = NUM_WAYS'(mask);
    #1;
    check(tag, int'(victim_way), m_victim(set, mask));
  endtask

  task automatic probe_const(input string tag, input int set, input int mask, input int exp);
    lookup_idx = IDX_W'(set);
    valid_ways = NUM_WAYS'(mask);
    #1;
    check(tag, int'(victim_way), exp);
  endtask

  initial begin
    int busy_cnt, done_cnt, last_busy, done_cyc;
    bit seen_done;

    rst_n = 1'b0; flush = 1'b0;
    hit_valid = 1'b0; hit_idx = '0; hit_way = '0;
    fill_valid = 1'b0; fill_idx = '0; fill_way = '0; fill_mru = 1'b0;
    lookup_idx = '0; valid_ways = '1;
    m_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(flush_done), 0);
    probe_const("rst_victim", 5, ALL_V, 0);

    // Touches on set 5
    update(1, 5, 0, 0, 0, 0, 0);
    probe_const("hit_w0_victim", 5, ALL_V, 2);
    probe_const("invalid_w2", 5, 4'b1011, 2);
    probe_const("all_invalid", 5, 4'b0000, 0);
    probe("invalid_w3", 5, 4'b0111);
    update(1, 5, 2, 0, 0, 0, 0);
    probe_const("hit_w2_victim", 5, ALL_V, 1);

    // LRU vs MRU insertion on set 9
    update(0, 0, 0, 1, 9, 3, 0);
    probe_const("fill_lru_w3", 9, ALL_V, 3);
    update(0, 0, 0, 1, 9, 3, 1);
    probe_const("fill_mru_w3", 9, ALL_V, 0);

    // Same-set and different-set fill + hit in one cycle
    update(1, 7, 3, 1, 7, 1, 1);
    probe_const("same_set_chain", 7, ALL_V, 0);
    update(1, 8, 3, 1, 7, 1, 1);
    probe_const("diff_set_fill", 7, ALL_V, 2);
    probe("diff_set_hit", 8, ALL_V);
    update(1, 11, 0, 1, 11, 0, 0);
    probe("same_set_hit_wins", 11, ALL_V);

    // Random traffic on a few sets to force collisions
    for (int c = 0; c < 400; c++) begin
      int s;
      update(bit'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, NUM_WAYS - 1),
             bit'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, NUM_WAYS - 1),
             bit'($urandom_range(0, 1)));
      s = $urandom_range(0, 3);
      probe("rand_victim", s, ($urandom_range(0, 1) == 1) ? ALL_V : $urandom_range(0, ALL_V));
    end

    // Flush sweep
    update(1, 0, 0, 0, 0, 0, 0);
    update(1, 128, 0, 0, 0, 0, 0);
    update(1, 255, 0, 0, 0, 0, 0);
    probe("dirty_255", 255, ALL_V);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    busy_cnt = 0; done_cnt = 0; last_busy = -1; done_cyc = -2; seen_done = 1'b0;
    for (int c = 0; c < 1000 && !seen_done; c++) begin
      if (busy) begin busy_cnt++; last_busy = c; end
      if (flush_done) begin done_cnt++; done_cyc = c; seen_done = 1'b1; end
      if (busy && busy_cnt == 1) probe_const("busy_victim", 255, ALL_V, 0);
      flush      = busy && busy_cnt == 10;
      hit_valid  = busy && busy_cnt == 50;
      hit_idx    = '0;
      hit_way    = '0;
      fill_valid = busy && busy_cnt == 50;
      fill_idx   = IDX_W'(1);
      fill_way   = WAY_W'(3);
      fill_mru   = 1'b0;
      tick();
    end
    flush = 1'b0; hit_valid = 1'b0; fill_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (flush_done) done_cnt++;
      tick();
    end
    m_clear();
    check("flush_busy_cycles", busy_cnt, 256);
    check("flush_done_count", done_cnt, 1);
    check("flush_done_timing", done_cyc, last_busy + 1);
    probe_const("flushed_0", 0, ALL_V, 0);
    probe_const("flushed_1", 1, ALL_V, 0);
    probe_const("flushed_128", 128, ALL_V, 0);
    probe_const("flushed_255", 255, ALL_V, 0);

    // Updates are live again after the sweep
    update(1, 128, 1, 0, 0, 0, 0);
    probe("post_flush_hit", 128, ALL_V);

    // Reset in the middle of a sweep
    update(1, 200, 0, 0, 0, 0, 0);
    update(1, 255, 3, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 300 && busy_cnt < 100; c++) begin
      if (busy) busy_cnt++;
      if (flush_done) done_cnt++;
      if (busy_cnt < 100) tick();
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(flush_done), 0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    m_clear();
    for (int c = 0; c < 300; c++) begin
      if (flush_done) done_cnt++;
      tick();
    end
    check("rst_mid_no_pulse", done_cnt, 0);
    check("rst_mid_idle", int'(busy), 0);
    probe_const("rst_mid_200", 200, ALL_V, 0);
    probe_const("rst_mid_255", 255, ALL_V, 0);
    probe("rst_mid_128", 128, ALL_V);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
